// File: rtl/dct_mac_accum.sv
// One-row signed MAC for a single DCT coefficient: rounds, shifts and saturates the sum.
// Latency is two enabled edges from the last sample to douten; ena=0 freezes every register.
module dct_mac_accum #(
   parameter int DWIDTH = 8,
   parameter int CWIDTH = 12,
   parameter int RWIDTH = 12,
   parameter int NTAPS  = 8,
   parameter int SHIFT  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              dstrb,
   input  logic [DWIDTH-1:0] din,
   input  logic [CWIDTH-1:0] coef,
   output logic [RWIDTH-1:0] dout,
   output logic              douten,
   output logic              busy
);

   localparam int CNTW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam int PW   = DWIDTH + CWIDTH;
   localparam int ACCW = DWIDTH + CWIDTH + $clog2(NTAPS);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ACCUM = 1'b1;

   localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NTAPS - 1);
   localparam logic signed [ACCW:0] HALF   = (ACCW+1)'(2 ** (SHIFT - 1));
   localparam logic signed [ACCW:0] SATMAX = (ACCW+1)'(2 ** (RWIDTH - 1) - 1);
   localparam logic signed [ACCW:0] SATMIN = -SATMAX - (ACCW+1)'(1);

   logic [0:0]             state;
   logic [CNTW-1:0]        cnt;
   logic signed [PW-1:0]   p;
   logic                   pvld, pfirst, plast;
   logic signed [ACCW-1:0] acc;

   logic                   accept;
   logic [CNTW-1:0]        idx;
   logic                   is_last;
   logic signed [PW-1:0]   prod;
   logic signed [ACCW-1:0] acc_base, acc_next;
   logic signed [ACCW:0]   rnd, shr;
   logic [RWIDTH-1:0]      sat_val;

   // dstrb always wins: it forces sample 0, even over the last sample of a row
   assign accept  = dstrb || (state == ACCUM);
   assign idx     = dstrb ? '0 : cnt;
   assign is_last = accept && (idx == LAST_IDX);
   assign prod    = PW'($signed(din)) * PW'($signed(coef));

   assign acc_base = pfirst ? '0 : acc;
   assign acc_next = acc_base + ACCW'(p);
   assign rnd      = (ACCW+1)'(acc_next) + HALF;
   assign shr      = rnd >>> SHIFT;

   always_comb begin
      sat_val = RWIDTH'(shr);
      if (shr > SATMAX)
         sat_val = RWIDTH'(SATMAX);
      else if (shr < SATMIN)
         sat_val = RWIDTH'(SATMIN);
   end

   assign busy = (state == ACCUM);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         p      <= '0;
         pvld   <= 1'b0;
         pfirst <= 1'b0;
         plast  <= 1'b0;
      end else if (ena) begin
         pvld <= accept;
         if (accept) begin
            p      <= prod;
            pfirst <= (idx == '0);
            plast  <= is_last;
            if (is_last) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               state <= ACCUM;
               cnt   <= idx + CNTW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc    <= '0;
         dout   <= '0;
         douten <= 1'b0;
      end else if (ena) begin
         douten <= 1'b0;
         if (pvld) begin
            acc <= acc_next;
            if (plast) begin
               dout   <= sat_val;
               douten <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dct_mac_accum.sv
// Directed bench for dct_mac_accum with hand-computed results.
module tb_dct_mac_accum;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ena = 1'b1;
   logic        dstrb = 1'b0;
   logic [7:0]  din = '0;
   logic [11:0] coef = '0;
   logic [11:0] dout;
   logic        douten;
   logic        busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int pulses = 0;
   int last_dout = 0;
   int last_pc = 0;
   int prev_pc = 0;

   dct_mac_accum dut (
      .clk(clk), .rst(rst), .ena(ena), .dstrb(dstrb), .din(din), .coef(coef),
      .dout(dout), .douten(douten), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // douten held across ena=0 edges is counted once, on the enabled edge that set it
   task automatic step();
      logic e;
      e = ena;
      @(posedge clk);
      #1;
      cyc++;
      if (douten && e) begin
         pulses++;
         last_dout = $signed(dout);
         prev_pc = last_pc;
         last_pc = cyc;
      end
   endtask

   task automatic sample(input logic s, input int d, input int c);
      dstrb = s;
      din   = d[7:0];
      coef  = c[11:0];
      step();
   endtask

   task automatic idle_inputs();
      dstrb = 1'b0;
      din   = '0;
      coef  = '0;
   endtask

   task automatic row(input int d, input int c);
      for (int i = 0; i < 8; i++) sample(i == 0, d, c);
      idle_inputs();
   endtask

   task automatic one_hot_row(input int d, input int c);
      sample(1'b1, d, c);
      for (int i = 1; i < 8; i++) sample(1'b0, 0, 0);
      idle_inputs();
      step();
      step();
   endtask

   initial begin
      #23;
      check("rst_dout", int'(dout), 0);
      check("rst_douten", int'(douten), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b1;
      step();

      // 1: basic row and latency
      pulses = 0;
      sample(1'b1, 1, 1024);
      check("t1_busy", int'(busy), 1);
      for (int i = 1; i < 8; i++) sample(1'b0, 1, 1024);
      idle_inputs();
      check("t1_busy_end", int'(busy), 0);
      check("t1_lat1", int'(douten), 0);
      step();
      check("t1_douten", int'(douten), 1);
      check("t1_dout", $signed(dout), 8);
      step();
      check("t1_pulse_len", int'(douten), 0);
      check("t1_hold", $signed(dout), 8);

      // 2: positive saturation
      row(-128, -2048);
      step();
      step();
      check("t2_sat", last_dout, 2047);

      // 3: rounding
      one_hot_row(1, 512);
      check("t3_half_up", last_dout, 1);
      one_hot_row(1, -512);
      check("t3_neg_half", last_dout, 0);
      one_hot_row(1, -513);
      check("t3_neg_past", last_dout, -1);

      // 4: back-to-back rows
      pulses = 0;
      row(1, 1024);
      row(2, 1024);
      step();
      step();
      check("t4_pulses", pulses, 2);
      check("t4_dout", last_dout, 16);
      check("t4_spacing", last_pc - prev_pc, 8);

      // 5: restart at sample 4
      pulses = 0;
      for (int i = 0; i < 4; i++) sample(i == 0, 1, 1024);
      row(3, 1024);
      step();
      step();
      check("t5_pulses", pulses, 1);
      check("t5_dout", last_dout, 24);

      // dstrb coincident with the last sample restarts the row
      pulses = 0;
      for (int i = 0; i < 7; i++) sample(i == 0, 5, 1024);
      row(1, 1024);
      step();
      step();
      check("t5b_pulses", pulses, 1);
      check("t5b_dout", last_dout, 8);

      // 6: ena toggling, ignored samples carry garbage
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         ena = (i % 2 == 0);
         sample(i == 0, (i % 2 == 0) ? 1 : 100, 1024);
      end
      idle_inputs();
      ena = 1'b1;
      step();
      check("t6_douten", int'(douten), 1);
      check("t6_dout", $signed(dout), 8);
      ena = 1'b0;
      step();
      check("t6_douten_hold", int'(douten), 1);
      ena = 1'b1;
      step();
      check("t6_douten_drop", int'(douten), 0);
      check("t6_pulses", pulses, 1);

      // async reset mid-row
      sample(1'b1, 3, 1024);
      sample(1'b0, 3, 1024);
      sample(1'b0, 3, 1024);
      check("t6_busy_pre", int'(busy), 1);
      #2 rst = 1'b0;
      #1;
      check("t6_rst_dout", int'(dout), 0);
      check("t6_rst_douten", int'(douten), 0);
      check("t6_rst_busy", int'(busy), 0);
      idle_inputs();
      #2 rst = 1'b1;
      pulses = 0;
      step();
      check("t6_rst_nopulse", pulses, 0);
      row(1, 1024);
      step();
      step();
      check("t6_after_rst", last_dout, 8);
      check("t6_after_rst_pulses", pulses, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
